// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED pattern engine.
// Mode encodings, bounce direction type and the per-mode seed pattern.
package led_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int SEED_W = 32;

    // The seed only ever has bit 0 set, so callers size-cast it to any LED width.
    function automatic logic [SEED_W-1:0] seed(input logic [1:0] mode);
        return (mode == MODE_COUNT) ? '0 : SEED_W'(1);
    endfunction

endpackage

// File: rtl/tick_presc.sv
// Free-running down-counter that pulses tick once every PRESC cycles.
// restart reloads the counter so the next tick is a full period away.
module tick_presc #(
    parameter int PRESC = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PRESC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: rotate left/right, bounce and binary count,
// advanced by a prescaled tick while running or by rising edges on step_i.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LEDS_NR = 6,
    parameter int PRESC   = 12_000_000,
    parameter int INV_OUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode_i,
    input  logic               run_i,
    input  logic               step_i,
    output logic [LEDS_NR-1:0] led,
    output logic               tick_o
);

    localparam logic [LEDS_NR-1:0] INV_MASK = (INV_OUT != 0) ? '1 : '0;

    logic [1:0]         r_mode;
    logic [LEDS_NR-1:0] r_pat;
    dir_e               r_dir;
    logic               r_step_q;
    logic               r_tick;

    logic               w_tick;
    logic               w_mode_chg;
    logic               w_step_e;
    logic               w_adv;
    logic [LEDS_NR-1:0] w_seed;
    logic [LEDS_NR-1:0] w_rot_l;
    logic [LEDS_NR-1:0] w_rot_r;
    logic [LEDS_NR-1:0] w_next_pat;
    dir_e               w_next_dir;

    assign w_mode_chg = (mode_i != r_mode);
    assign w_step_e   = step_i & ~r_step_q;
    assign w_adv      = (w_tick & run_i) | w_step_e;
    assign w_seed     = LEDS_NR'(seed(mode_i));

    tick_presc #(
        .PRESC(PRESC)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .restart (w_mode_chg),
        .tick    (w_tick)
    );

    // A single LED has nowhere to rotate to, so both rotations hold it.
    generate
        if (LEDS_NR == 1) begin : g_one
            assign w_rot_l = r_pat;
            assign w_rot_r = r_pat;
        end else begin : g_multi
            assign w_rot_l = {r_pat[LEDS_NR-2:0], r_pat[LEDS_NR-1]};
            assign w_rot_r = {r_pat[0], r_pat[LEDS_NR-1:1]};
        end
    endgenerate

    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        case (r_mode)
            MODE_ROT_L: w_next_pat = w_rot_l;
            MODE_ROT_R: w_next_pat = w_rot_r;
            MODE_BOUNCE: begin
                // Turn around on the step that reaches an end, so end LEDs show once.
                if (LEDS_NR > 1) begin
                    if (r_dir == DIR_LEFT) begin
                        if (r_pat[LEDS_NR-1]) begin
                            w_next_pat = r_pat >> 1;
                            w_next_dir = DIR_RIGHT;
                        end else begin
                            w_next_pat = r_pat << 1;
                        end
                    end else begin
                        if (r_pat[0]) begin
                            w_next_pat = r_pat << 1;
                            w_next_dir = DIR_LEFT;
                        end else begin
                            w_next_pat = r_pat >> 1;
                        end
                    end
                end
            end
            default: w_next_pat = r_pat + LEDS_NR'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= mode_i;
            r_pat    <= w_seed;
            r_dir    <= DIR_LEFT;
            r_step_q <= step_i;
            r_tick   <= 1'b0;
        end else begin
            r_step_q <= step_i;
            if (w_mode_chg) begin
                r_mode <= mode_i;
                r_pat  <= w_seed;
                r_dir  <= DIR_LEFT;
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_adv;
                if (w_adv) begin
                    r_pat <= w_next_pat;
                    r_dir <= w_next_dir;
                end
            end
        end
    end

    assign led    = r_pat ^ INV_MASK;
    assign tick_o = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen using two instances
// (4 LEDs / PRESC 4 / active-high and 1 LED / PRESC 3 / active-low).
module tb_led_pattern_gen;

    localparam int N0 = 4;
    localparam int P0 = 4;
    localparam int N1 = 1;
    localparam int P1 = 3;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic          run_i  = 1'b0;
    logic          step_i = 1'b0;
    logic [N0-1:0] led0;
    logic          tick0;
    logic [N1-1:0] led1;
    logic          tick1;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.LEDS_NR(N0), .PRESC(P0), .INV_OUT(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_i),
        .run_i  (run_i),
        .step_i (step_i),
        .led    (led0),
        .tick_o (tick0)
    );

    led_pattern_gen #(.LEDS_NR(N1), .PRESC(P1), .INV_OUT(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_i),
        .run_i  (run_i),
        .step_i (step_i),
        .led    (led1),
        .tick_o (tick1)
    );

    // Reference state: p counts advances since the last reset or mode change,
    // since counts cycles since then (a tick lands when since == PRESC-1).
    typedef struct {
        logic [1:0] mode;
        int         p;
        int         since;
        bit         step_prev;
        bit         tick_o;
    } model_t;

    model_t m0;
    model_t m1;

    function automatic model_t model_step(model_t s, int presc, bit r,
                                          logic [1:0] md, bit run, bit st);
        model_t n = s;
        bit tk;
        bit se;
        bit adv;
        if (r) begin
            n.mode = md; n.p = 0; n.since = 0; n.step_prev = st; n.tick_o = 0;
            return n;
        end
        tk = (s.since == presc - 1);
        se = st && !s.step_prev;
        n.step_prev = st;
        if (md != s.mode) begin
            n.mode = md; n.p = 0; n.since = 0; n.tick_o = 0;
        end else begin
            adv = (tk && run) || se;
            n.since = (s.since + 1) % presc;
            if (adv) n.p = s.p + 1;
            n.tick_o = adv;
        end
        return n;
    endfunction

    // Expected LED bus from mode and number of advances, computed positionally.
    function automatic logic [31:0] exp_led(int n, bit inv, logic [1:0] md, int p);
        logic [31:0] v;
        logic [31:0] mask;
        int k;
        int pos;
        mask = (32'd1 << n) - 32'd1;
        pos = 0;
        case (md)
            2'd0: pos = p % n;
            2'd1: pos = (n - p % n) % n;
            2'd2: begin
                if (n == 1) begin
                    pos = 0;
                end else begin
                    k = p % (2 * n - 2);
                    pos = (k < n) ? k : 2 * n - 2 - k;
                end
            end
            default: pos = 0;
        endcase
        if (md == 2'd3) v = 32'(p % (1 << n));
        else            v = 32'd1 << pos;
        if (inv) v = v ^ mask;
        return v & mask;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cycle(input bit r, input logic [1:0] md, input bit run, input bit st);
        @(negedge clk);
        rst    = r;
        mode_i = md;
        run_i  = run;
        step_i = st;
        m0 = model_step(m0, P0, r, md, run, st);
        m1 = model_step(m1, P1, r, md, run, st);
        @(posedge clk);
        #1;
        check_eq("led0",  32'(led0),  exp_led(N0, 1'b0, m0.mode, m0.p));
        check_eq("tick0", 32'(tick0), 32'(m0.tick_o));
        check_eq("led1",  32'(led1),  exp_led(N1, 1'b1, m1.mode, m1.p));
        check_eq("tick1", 32'(tick1), 32'(m1.tick_o));
    endtask

    initial begin
        logic [1:0] md;
        bit         run;
        bit         st;

        // Rotate left from reset.
        cycle(1'b1, 2'd0, 1'b1, 1'b0);
        check_eq("t1_reset_led", 32'(led0), 32'h1);
        check_eq("t1_reset_tick", 32'(tick0), 32'h0);
        repeat (20) cycle(1'b0, 2'd0, 1'b1, 1'b0);

        // Mode switch coinciding with a prescaler tick.
        while (m0.since != P0 - 1) cycle(1'b0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 2'd3, 1'b1, 1'b0);
        check_eq("t5_led", 32'(led0), 32'h0);
        check_eq("t5_tick", 32'(tick0), 32'h0);
        repeat (3) cycle(1'b0, 2'd3, 1'b1, 1'b0);
        check_eq("t5_hold", 32'(led0), 32'h0);
        cycle(1'b0, 2'd3, 1'b1, 1'b0);
        check_eq("t5_first_adv", 32'(led0), 32'h1);
        check_eq("t5_first_tick", 32'(tick0), 32'h1);

        // Count through a full wrap: 17 ticks land on 0001.
        cycle(1'b1, 2'd3, 1'b1, 1'b0);
        repeat (17 * P0) cycle(1'b0, 2'd3, 1'b1, 1'b0);
        check_eq("t3_wrap", 32'(led0), 32'h1);

        // Bounce.
        cycle(1'b1, 2'd2, 1'b1, 1'b0);
        repeat (40) cycle(1'b0, 2'd2, 1'b1, 1'b0);

        // Paused, manual steps only.
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (2)  cycle(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (3)  cycle(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (8)  cycle(1'b0, 2'd0, 1'b0, 1'b0);
        check_eq("t4_two_steps", 32'(led0), 32'h4);

        // Single active-low LED in bounce mode, then reset mid-run.
        cycle(1'b1, 2'd2, 1'b1, 1'b0);
        repeat (35) begin
            cycle(1'b0, 2'd2, 1'b1, 1'b0);
            check_eq("t6_led1", 32'(led1), 32'h0);
        end
        cycle(1'b1, 2'd2, 1'b1, 1'b0);
        check_eq("t6_reset_led1", 32'(led1), 32'h0);
        check_eq("t6_reset_tick1", 32'(tick1), 32'h0);

        // Random traffic.
        md  = 2'd0;
        run = 1'b1;
        st  = 1'b0;
        cycle(1'b1, md, run, st);
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0)  st = ~st;
            cycle(r, md, run, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine. It generalises the fixed one-hot rotate demo into several selectable modes, with a width-generic LED bus and a configurable step rate. It adds run/pause, a debounced-edge single-step input and optional active-low output. It sits between the board top level (clock, buttons/switches) and the LED pins.

Parameters:
LEDS_NR, 6, number of LED outputs; legal range ≥ 1.
PRESC, 12_000_000, clock cycles per automatic step; legal range ≥ 1.
INV_OUT, 0, 1 = LEDs active-low: led is the pattern register XOR all-ones.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
mode_i  in  2  pattern select: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT.
run_i  in  1  1 = advance on prescaler tick; 0 = paused.
step_i  in  1  level input; each rising edge causes one manual advance.
led  out  LEDS_NR  pattern output; combinational from the pattern register and INV_OUT only.
tick_o  out  1  one-cycle pulse on every cycle the pattern advances.

Behaviour:
- Reset (rst=1 at clk edge):
  - mode_q <= mode_i; pat <= seed(mode_i); dir <= LEFT.
  - cnt <= PRESC-1; step_q <= step_i.
  - Outputs on the next cycle: led = seed ^ {LEDS_NR{INV_OUT}}, tick_o = 0.
- seed(mode): COUNT gives all zeros; every other mode gives 'd1 (bit 0 lit).
- Prescaler:
  - cnt counts down every cycle, independent of run_i.
  - At cnt==0 it reloads PRESC-1 and asserts tick for that cycle, so tick period is exactly PRESC cycles.
  - PRESC=1 gives tick every cycle.
- Step edge: step_e = step_i & ~step_q; step_q <= step_i every cycle.
- Advance: adv = (tick & run_i) | step_e. A tick and a step edge in the same cycle advance once only.
- Mode change:
  - If mode_i != mode_q, then mode_q <= mode_i, pat <= seed(mode_i), dir <= LEFT, cnt <= PRESC-1.
  - Mode change has priority over adv; tick_o = 0 in that cycle.
- On adv with no mode change, tick_o <= 1 (registered, one cycle after the adv cycle) and pat updates per mode_q:
  - ROT_L: pat <= {pat[N-2:0], pat[N-1]}.
  - ROT_R: pat <= {pat[0], pat[N-1:1]}.
  - BOUNCE, dir LEFT:
    - If pat[N-1] is set: shift right and set dir <= RIGHT.
    - Otherwise shift left.
  - BOUNCE, dir RIGHT: mirror of the LEFT rule at pat[0].
  - BOUNCE sequence period is 2N-2 steps. End LEDs are lit for one step each, with no repeat.
  - COUNT: pat <= pat + 1, modulo 2^N; all-ones wraps to zero.
- LEDS_NR=1:
  - ROT_L, ROT_R and BOUNCE hold 1 (the BOUNCE rule must not shift out).
  - COUNT toggles.
- Paused (run_i=0): pat and dir hold, cnt keeps running, step edges still advance.
- Reset mid-sequence discards pattern and direction; there is no partial-state retention.

Decomposition:
- Package led_pkg holds:
  - mode constants MODE_ROT_L=2'd0, MODE_ROT_R=2'd1, MODE_BOUNCE=2'd2, MODE_COUNT=2'd3;
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1;
  - the seed function, parametrised on width.
- Sub-module tick_presc (params PRESC; ports clk, rst, restart, tick) holds the down-counter.
  - restart is driven by mode change.
  - Width is $clog2(PRESC), minimum 1.
- Everything else stays in led_pattern_gen.

Test Plan:
All directed tests use LEDS_NR=4, PRESC=4, INV_OUT=0 unless stated.
1. Reset with mode_i=0 and run_i=1, hold 20 cycles -> led sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles; tick_o pulses exactly every 4 cycles.
2. mode_i=2, run_i=1 -> led 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; the end values are never repeated.
3. mode_i=3, run_i=1, 17 ticks -> led counts 0000..1111 then wraps to 0000 then 0001.
4. run_i=0, step_i held high 10 cycles, then low, then high -> exactly 2 advances (0001→0010→0100); no advance from the prescaler.
5. Switch mode_i 0→3 in the same cycle as a prescaler tick -> next led = 0000, tick_o=0; first advance comes exactly 4 cycles later.
6. INV_OUT=1, LEDS_NR=1, mode_i=2 -> led stays 0 (active-low lit) for 10 ticks; assert rst mid-run -> led 0 one cycle after rst.
